// File: rtl/dircc_send_fanout.sv
`default_nettype none
// ============================================================================
// Module   : dircc_send_fanout
// Purpose  : Buffers send-handler packets and fans each one out to every
//            destination listed in the device's output-edge table.
// Revision : 1.0 - initial release
// ============================================================================
module dircc_send_fanout #(
    parameter int ADDRESS_MEM_WIDTH = 32,
    parameter int PACKET_WIDTH      = 64,
    parameter int FIFO_DEPTH        = 4,
    parameter int FANOUT_WIDTH      = 5,
    parameter int EDGE_ADDR_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [PACKET_WIDTH-1:0]      packet_in,
    input  logic                         packet_in_valid,
    output logic                         packet_in_ready,
    input  logic [EDGE_ADDR_WIDTH-1:0]   edge_base,
    input  logic [FANOUT_WIDTH-1:0]      fanout_count,
    output logic                         edge_rd_en,
    output logic [EDGE_ADDR_WIDTH-1:0]   edge_rd_addr,
    input  logic [ADDRESS_MEM_WIDTH-1:0] edge_rd_data,
    output logic [PACKET_WIDTH-1:0]      net_packet,
    output logic [ADDRESS_MEM_WIDTH-1:0] net_dest_address,
    output logic                         net_valid,
    input  logic                         net_ready,
    output logic                         busy,
    output logic [31:0]                  sent_count,
    output logic [15:0]                  dropped_count
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_ENTRY_W = PACKET_WIDTH + EDGE_ADDR_WIDTH + FANOUT_WIDTH;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_SEND  = 2'd3;

    logic [c_ENTRY_W-1:0]         r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]             r_wr_ptr;
    logic [c_PTR_W:0]             r_rd_ptr;
    logic [1:0]                   r_state;
    logic [PACKET_WIDTH-1:0]      r_pkt;
    logic [EDGE_ADDR_WIDTH-1:0]   r_base;
    logic [FANOUT_WIDTH-1:0]      r_cnt;
    logic [FANOUT_WIDTH-1:0]      r_idx;
    logic [PACKET_WIDTH-1:0]      r_net_packet;
    logic [ADDRESS_MEM_WIDTH-1:0] r_net_dest;
    logic                         r_net_valid;
    logic [31:0]                  r_sent;
    logic [15:0]                  r_dropped;

    logic [c_PTR_W:0]             w_count;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic [c_ENTRY_W-1:0]         w_head;
    logic [PACKET_WIDTH-1:0]      w_head_pkt;
    logic [EDGE_ADDR_WIDTH-1:0]   w_head_base;
    logic [FANOUT_WIDTH-1:0]      w_head_cnt;
    logic [FANOUT_WIDTH-1:0]      w_idx_next;
    logic [EDGE_ADDR_WIDTH-1:0]   w_rd_addr;
    logic                         w_fetch;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == (c_PTR_W+1)'(FIFO_DEPTH));
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_push      = packet_in_valid && !w_full;
    assign w_pop       = (r_state == c_IDLE) && !w_empty;

    assign w_head      = r_fifo_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign w_head_pkt  = w_head[c_ENTRY_W-1 -: PACKET_WIDTH];
    assign w_head_base = w_head[FANOUT_WIDTH +: EDGE_ADDR_WIDTH];
    assign w_head_cnt  = w_head[FANOUT_WIDTH-1:0];

    assign w_idx_next  = r_idx + 1'b1;
    assign w_rd_addr   = r_base + EDGE_ADDR_WIDTH'(r_idx);
    assign w_fetch     = (r_state == c_FETCH);

    assign packet_in_ready  = !w_full;
    assign edge_rd_en       = w_fetch;
    assign edge_rd_addr     = w_fetch ? w_rd_addr : '0;
    assign net_packet       = r_net_packet;
    assign net_dest_address = r_net_dest;
    assign net_valid        = r_net_valid;
    assign busy             = !w_empty || (r_state != c_IDLE);
    assign sent_count       = r_sent;
    assign dropped_count    = r_dropped;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[c_PTR_W-1:0]] <= {packet_in, edge_base, fanout_count};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_state      <= c_IDLE;
            r_pkt        <= '0;
            r_base       <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_net_packet <= '0;
            r_net_dest   <= '0;
            r_net_valid  <= 1'b0;
            r_sent       <= '0;
            r_dropped    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (!w_empty) begin
                        if (w_head_cnt == '0) begin
                            if (r_dropped != 16'hFFFF) begin
                                r_dropped <= r_dropped + 16'd1;
                            end
                        end else begin
                            r_pkt   <= w_head_pkt;
                            r_base  <= w_head_base;
                            r_cnt   <= w_head_cnt;
                            r_idx   <= '0;
                            r_state <= c_FETCH;
                        end
                    end
                end
                c_FETCH: begin
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    // Edge-table data arrives one cycle after the FETCH strobe.
                    r_net_dest   <= edge_rd_data;
                    r_net_packet <= r_pkt;
                    r_net_valid  <= 1'b1;
                    r_state      <= c_SEND;
                end
                c_SEND: begin
                    if (r_net_valid && net_ready) begin
                        r_sent      <= r_sent + 32'd1;
                        r_idx       <= w_idx_next;
                        r_net_valid <= 1'b0;
                        r_state     <= (w_idx_next == r_cnt) ? c_IDLE : c_FETCH;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dircc_send_fanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_dircc_send_fanout
// Purpose  : Self-checking bench for dircc_send_fanout with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dircc_send_fanout;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] packet_in;
    logic        packet_in_valid;
    logic        packet_in_ready;
    logic [7:0]  edge_base;
    logic [4:0]  fanout_count;
    logic        edge_rd_en;
    logic [7:0]  edge_rd_addr;
    logic [31:0] edge_rd_data;
    logic [63:0] net_packet;
    logic [31:0] net_dest_address;
    logic        net_valid;
    logic        net_ready;
    logic        busy;
    logic [31:0] sent_count;
    logic [15:0] dropped_count;

    always #5 clk = ~clk;

    dircc_send_fanout dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .packet_in        (packet_in),
        .packet_in_valid  (packet_in_valid),
        .packet_in_ready  (packet_in_ready),
        .edge_base        (edge_base),
        .fanout_count     (fanout_count),
        .edge_rd_en       (edge_rd_en),
        .edge_rd_addr     (edge_rd_addr),
        .edge_rd_data     (edge_rd_data),
        .net_packet       (net_packet),
        .net_dest_address (net_dest_address),
        .net_valid        (net_valid),
        .net_ready        (net_ready),
        .busy             (busy),
        .sent_count       (sent_count),
        .dropped_count    (dropped_count)
    );

    // Edge table: synchronous-read memory.
    logic [31:0] tbl [256];
    always @(posedge clk) if (edge_rd_en) edge_rd_data <= tbl[edge_rd_addr];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every accepted push expands into its expected reads and beats.
    logic [95:0] exp_beat_q [$];
    logic [7:0]  exp_addr_q [$];
    logic [7:0]  rd_log [$];
    int          acc_edges [$];
    int          exp_total = 0, exp_drops = 0;
    int          n_push = 0, n_acc = 0, n_reads = 0;
    int          push_edge = 0, first_rise = -1;
    logic        prev_valid = 1'b0, prev_ready = 1'b0;
    logic [63:0] prev_pkt = '0;
    logic [31:0] prev_dest = '0;
    logic [7:0]  m_a;
    logic [95:0] m_eb;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_beat_q.delete();
            exp_addr_q.delete();
            exp_total  = 0;
            exp_drops  = 0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (packet_in_valid && packet_in_ready) begin
                n_push++;
                push_edge = int'(cyc) + 1;
                if (fanout_count == 5'd0) exp_drops++;
                for (int i = 0; i < int'(fanout_count); i++) begin
                    m_a = edge_base + 8'(i);
                    exp_addr_q.push_back(m_a);
                    exp_beat_q.push_back({packet_in, tbl[m_a]});
                    exp_total++;
                end
            end
            if (edge_rd_en) begin
                n_reads++;
                rd_log.push_back(edge_rd_addr);
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL edge_read: unexpected read of %h, none required", edge_rd_addr);
                end else begin
                    m_a = exp_addr_q.pop_front();
                    if (edge_rd_addr !== m_a) begin
                        n_fail++;
                        $display("FAIL edge_read: addr %h, required %h", edge_rd_addr, m_a);
                    end
                end
            end
            if (net_valid && !prev_valid && first_rise < 0) first_rise = int'(cyc);
            if (prev_valid && !prev_ready) begin
                n_checks++;
                if ({net_valid, net_packet, net_dest_address} !== {1'b1, prev_pkt, prev_dest}) begin
                    n_fail++;
                    $display("FAIL hold_stable: v=%b pkt=%h dest=%h, required v=1 pkt=%h dest=%h",
                             net_valid, net_packet, net_dest_address, prev_pkt, prev_dest);
                end
            end
            if (net_valid && net_ready) begin
                n_acc++;
                acc_edges.push_back(int'(cyc) + 1);
                n_checks++;
                if (exp_beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: unexpected beat pkt=%h dest=%h", net_packet, net_dest_address);
                end else begin
                    m_eb = exp_beat_q.pop_front();
                    if ({net_packet, net_dest_address} !== m_eb) begin
                        n_fail++;
                        $display("FAIL beat: pkt=%h dest=%h, required pkt=%h dest=%h",
                                 net_packet, net_dest_address, m_eb[95:32], m_eb[31:0]);
                    end
                end
            end
            prev_valid = net_valid;
            prev_ready = net_ready;
            prev_pkt   = net_packet;
            prev_dest  = net_dest_address;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] p, input logic [7:0] b, input logic [4:0] f);
        int waitc = 0;
        packet_in       = p;
        edge_base       = b;
        fanout_count    = f;
        packet_in_valid = 1'b1;
        @(negedge clk);
        while (!packet_in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (!packet_in_ready) begin
            n_fail++;
            $display("FAIL push_timeout: ready=%b, required 1", packet_in_ready);
        end
        @(posedge clk);
        #1;
        packet_in_valid = 1'b0;
    endtask

    task automatic drain();
        int waitc = 0;
        @(negedge clk);
        while ((busy || exp_beat_q.size() != 0) && waitc < 2000) begin
            @(negedge clk);
            waitc++;
        end
        n_checks++;
        if (busy || exp_beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: busy=%b pending=%0d, required idle", busy, exp_beat_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; packet_in = '0; packet_in_valid = 1'b0; edge_base = '0;
        fanout_count = '0; net_ready = 1'b0;
        step(3);
        n_checks++; if (net_valid !== 1'b0)        begin n_fail++; $display("FAIL rst_net_valid: %b, required 0", net_valid); end
        n_checks++; if (edge_rd_en !== 1'b0)       begin n_fail++; $display("FAIL rst_rd_en: %b, required 0", edge_rd_en); end
        n_checks++; if (sent_count !== 32'd0)      begin n_fail++; $display("FAIL rst_sent: %0d, required 0", sent_count); end
        reset_n = 1'b1;
        step(1);
        n_checks++; if (dropped_count !== 16'd0)   begin n_fail++; $display("FAIL rst_dropped: %0d, required 0", dropped_count); end
        n_checks++; if (busy !== 1'b0)             begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
        n_checks++; if (packet_in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_ready: %b, required 1", packet_in_ready); end
        n_checks++; if ({net_packet, net_dest_address, edge_rd_addr} !== 104'd0) begin
            n_fail++; $display("FAIL rst_data: pkt=%h dest=%h addr=%h, required 0", net_packet, net_dest_address, edge_rd_addr);
        end
    endtask

    task automatic test_single();
        tbl[8'h10] = 32'hA000_0000; tbl[8'h11] = 32'hA000_0001; tbl[8'h12] = 32'hA000_0002;
        net_ready = 1'b1;
        first_rise = -1;
        rd_log.delete();
        push(64'hDEAD_BEEF_0123_4567, 8'h10, 5'd3);
        drain();
        n_checks++; if (first_rise - push_edge != 3) begin n_fail++; $display("FAIL single_latency: %0d, required 3", first_rise - push_edge); end
        n_checks++; if (sent_count !== 32'd3) begin n_fail++; $display("FAIL single_sent: %0d, required 3", sent_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: %b, required 0", busy); end
        n_checks++; if (rd_log.size() != 3) begin n_fail++; $display("FAIL single_reads: %0d, required 3", rd_log.size()); end
    endtask

    task automatic test_backpressure();
        int waitc = 0;
        int a0, k, r0;
        net_ready = 1'b1;
        a0 = n_acc;
        push({$urandom, $urandom}, 8'h40, 5'd3);
        @(negedge clk);
        while (n_acc < a0 + 1 && waitc < 50) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        net_ready = 1'b0;
        waitc = 0;
        @(negedge clk);
        while (!net_valid && waitc < 50) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        r0 = n_reads;
        step(5);
        n_checks++; if (net_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: %b, required 1", net_valid); end
        n_checks++; if (n_reads != r0) begin n_fail++; $display("FAIL bp_extra_reads: %0d, required 0", n_reads - r0); end
        k = n_acc;
        net_ready = 1'b1;
        step(1);
        n_checks++; if (n_acc != k + 1) begin n_fail++; $display("FAIL bp_accept: %0d beats, required 1", n_acc - k); end
        n_checks++; if (net_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: %b, required 0", net_valid); end
        drain();
        n_checks++; if (sent_count !== 32'(exp_total)) begin n_fail++; $display("FAIL bp_sent: %0d, required %0d", sent_count, exp_total); end
    endtask

    task automatic test_fifo_fill();
        int p0;
        int s0;
        logic [4:0] exp_rdy;
        s0 = int'(sent_count);
        net_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push({32'hF1F0_0000 + 32'(i), $urandom}, 8'(8'h60 + 8'(4 * i)), 5'd2);
            exp_rdy = 5'b01111;
            n_checks++;
            if (packet_in_ready !== exp_rdy[i]) begin
                n_fail++; $display("FAIL fill_ready_%0d: %b, required %b", i, packet_in_ready, exp_rdy[i]);
            end
        end
        p0 = n_push;
        packet_in = 64'h6666_6666_6666_6666; edge_base = 8'h80; fanout_count = 5'd1;
        packet_in_valid = 1'b1;
        step(4);
        n_checks++; if (packet_in_ready !== 1'b0 || n_push != p0) begin
            n_fail++; $display("FAIL fill_stall: ready=%b extra_pushes=%0d, required 0/0", packet_in_ready, n_push - p0);
        end
        packet_in_valid = 1'b0;
        net_ready = 1'b1;
        drain();
        n_checks++; if (int'(sent_count) - s0 != 10) begin n_fail++; $display("FAIL fill_sent: %0d, required 10", int'(sent_count) - s0); end
    endtask

    task automatic test_zero_fanout();
        int a0, r0, d0;
        a0 = n_acc; r0 = n_reads; d0 = int'(dropped_count);
        net_ready = 1'b1;
        push(64'h0, 8'h20, 5'd0);
        push(64'h1111, 8'h21, 5'd1);
        push(64'h2222, 8'h22, 5'd0);
        drain();
        n_checks++; if (n_acc - a0 != 1) begin n_fail++; $display("FAIL zero_beats: %0d, required 1", n_acc - a0); end
        n_checks++; if (int'(dropped_count) - d0 != 2) begin n_fail++; $display("FAIL zero_dropped: %0d, required 2", int'(dropped_count) - d0); end
        n_checks++; if (n_reads - r0 != 1) begin n_fail++; $display("FAIL zero_reads: %0d, required 1", n_reads - r0); end
    endtask

    task automatic test_wrap();
        logic [23:0] got;
        rd_log.delete();
        net_ready = 1'b1;
        push(64'hABCD, 8'hFE, 5'd3);
        drain();
        got = (rd_log.size() == 3) ? {rd_log[0], rd_log[1], rd_log[2]} : 24'hxxxxxx;
        n_checks++; if (got !== 24'hFE_FF_00) begin n_fail++; $display("FAIL wrap_addrs: %h, required feff00", got); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        acc_edges.delete();
        net_ready = 1'b1;
        push(64'hB2B0, 8'h30, 5'd2);
        push(64'hB2B1, 8'h38, 5'd1);
        drain();
        d1 = (acc_edges.size() == 3) ? acc_edges[1] - acc_edges[0] : -1;
        d2 = (acc_edges.size() == 3) ? acc_edges[2] - acc_edges[1] : -1;
        n_checks++; if (d1 != 3) begin n_fail++; $display("FAIL b2b_intra_gap: %0d, required 3", d1); end
        n_checks++; if (d2 != 4) begin n_fail++; $display("FAIL b2b_inter_gap: %0d, required 4", d2); end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        for (int i = 0; i < 256; i++) tbl[i] = $urandom;
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    push({$urandom, $urandom}, 8'($urandom), 5'($urandom_range(0, 6)));
                    if ($urandom_range(0, 2) == 0) step($urandom_range(1, 6));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    net_ready = ($urandom_range(0, 3) != 0);
                end
                net_ready = 1'b1;
            end
        join
        drain();
        n_checks++; if (sent_count !== 32'(exp_total)) begin n_fail++; $display("FAIL rand_sent: %0d, required %0d", sent_count, exp_total); end
        n_checks++; if (dropped_count !== 16'(exp_drops)) begin n_fail++; $display("FAIL rand_dropped: %0d, required %0d", dropped_count, exp_drops); end
        n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL rand_reads: %0d missing, required 0", exp_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        int waitc = 0;
        int a0;
        net_ready = 1'b0;
        push(64'h7000, 8'h50, 5'd2);
        push(64'h7001, 8'h54, 5'd2);
        push(64'h7002, 8'h58, 5'd2);
        @(negedge clk);
        while (!net_valid && waitc < 50) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (net_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: %b, required 0", net_valid); end
        n_checks++; if (sent_count !== 32'd0 || dropped_count !== 16'd0) begin
            n_fail++; $display("FAIL rmid_counters: sent=%0d dropped=%0d, required 0/0", sent_count, dropped_count);
        end
        step(2);
        reset_n = 1'b1;
        a0 = n_acc;
        net_ready = 1'b1;
        step(20);
        n_checks++; if (n_acc != a0) begin n_fail++; $display("FAIL rmid_beats: %0d, required 0", n_acc - a0); end
        n_checks++; if (packet_in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_idle: ready=%b busy=%b, required 1/0", packet_in_ready, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tbl[i] = $urandom;
        test_reset();
        test_single();
        test_backpressure();
        test_fifo_fill();
        test_zero_fanout();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
